// File: rtl/gf2_pkg.sv
// Shared types and width helpers for the GF(2) minimum-weight solver.
package gf2_pkg;

   function automatic int clog2p1(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int GF2_MAX_ROWS = 4;
   localparam int GF2_MAX_COLS = 7;
   localparam int GF2_COLS_W   = clog2p1(GF2_MAX_COLS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      ENUM = 2'd2,
      DONE = 2'd3
   } solve_state_e;

   typedef struct packed {
      logic                  vld;
      logic [GF2_COLS_W-1:0] col;
   } pivot_t;

endpackage

// File: rtl/gf2_popcount.sv
// Combinational population count of a W-bit vector.
module gf2_popcount
   import gf2_pkg::*;
#(
   parameter  int W  = 6,
   localparam int CW = clog2p1(W)
) (
   input  logic [W-1:0]  vec,
   output logic [CW-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < W; i++) cnt = cnt + CW'(vec[i]);
   end

endmodule

// File: rtl/gf2_min_weight_solve.sv
// Minimum Hamming-weight solution of a reduced GF(2) system by free-variable enumeration.
// Optional macro GF2_SOLVE_SOL_VEC_EN adds the best_sol register and min_sol output port.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold
// SCAN  | one matrix row per cycle: find pivot, flag 0 = 1 rows
// ENUM  | one free-variable subset per cycle, track lightest solution
// DONE  | one-cycle done pulse, results valid
module gf2_min_weight_solve
   import gf2_pkg::*;
#(
   parameter  int MAX_ROWS = GF2_MAX_ROWS,
   parameter  int MAX_COLS = GF2_MAX_COLS,
   localparam int ROWS_W   = clog2p1(MAX_ROWS),
   localparam int COLS_W   = clog2p1(MAX_COLS),
   localparam int WGT_W    = COLS_W,
   localparam int VW       = MAX_COLS - 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [ROWS_W-1:0]                  rows,
   input  logic [COLS_W-1:0]                  cols,
   input  logic                               start,
   input  logic [MAX_ROWS-1:0][MAX_COLS-1:0]  RREF,
   output logic                               busy,
   output logic                               done,
   output logic                               sol_ok,
   output logic [WGT_W-1:0]                   min_weight
`ifdef GF2_SOLVE_SOL_VEC_EN
   ,
   output logic [VW-1:0]                      min_sol
`endif
);

   localparam int RIDX_W = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;

   solve_state_e        state;
   logic [ROWS_W-1:0]   rows_q;
   logic [RIDX_W-1:0]   ridx_q;
   logic [VW-1:0]       row_vars_q [MAX_ROWS];
   logic [MAX_ROWS-1:0] rhs_q;
   pivot_t              piv_q [MAX_ROWS];
   logic [VW-1:0]       free_q;
   logic                incons_q;
   logic [VW-1:0]       s_q;
   logic [WGT_W-1:0]    best_q;
`ifdef GF2_SOLVE_SOL_VEC_EN
   logic [VW-1:0]       best_sol_q;
`endif

   logic [ROWS_W-1:0]   rows_eff;
   logic [COLS_W-1:0]   cols_eff;
   logic [VW-1:0]       vmask_in;
   logic [MAX_COLS-1:0] rhs_sel_in;
   logic [VW-1:0]       scan_vars;
   logic                piv_hit;
   logic [COLS_W-1:0]   piv_col;
   logic                scan_incons;
   logic                row_last;
   logic [VW-1:0]       x_c;
   logic [WGT_W-1:0]    w_c;
   logic [VW-1:0]       s_next;
   logic                better;

   // Request decode: clamp sizes, split each row into variable bits and its RHS bit.
   always_comb begin
      rows_eff = (rows > ROWS_W'(MAX_ROWS)) ? ROWS_W'(MAX_ROWS) : rows;
      cols_eff = (cols > COLS_W'(MAX_COLS)) ? COLS_W'(MAX_COLS) : cols;
      if (cols_eff == '0) cols_eff = COLS_W'(1);
      vmask_in   = '0;
      rhs_sel_in = '0;
      for (int i = 0; i < VW; i++) vmask_in[i] = (i + 1 < int'(cols_eff));
      for (int c = 0; c < MAX_COLS; c++) rhs_sel_in[c] = (c + 1 == int'(cols_eff));
   end

   always_comb begin
      scan_vars = row_vars_q[ridx_q];
      piv_hit   = |scan_vars;
      piv_col   = '0;
      for (int c = VW - 1; c >= 0; c--) begin
         if (scan_vars[c]) piv_col = COLS_W'(c);
      end
      scan_incons = incons_q | (~piv_hit & rhs_q[ridx_q]);
      row_last    = (ROWS_W'(ridx_q) + ROWS_W'(1)) == rows_q;
   end

   // Candidate: free bits straight from the subset, each pivot solved by its row.
   always_comb begin
      x_c = s_q;
      for (int r = 0; r < MAX_ROWS; r++) begin
         if (piv_q[r].vld) x_c[piv_q[r].col] = rhs_q[r] ^ (^(row_vars_q[r] & s_q));
      end
      s_next = (s_q - free_q) & free_q;
      better = (w_c < best_q);
   end

   gf2_popcount #(.W(VW)) u_popcount (
      .vec (x_c),
      .cnt (w_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rows_q     <= '0;
         ridx_q     <= '0;
         rhs_q      <= '0;
         free_q     <= '0;
         incons_q   <= 1'b0;
         s_q        <= '0;
         best_q     <= '1;
         busy       <= 1'b0;
         done       <= 1'b0;
         sol_ok     <= 1'b0;
         min_weight <= '0;
         for (int r = 0; r < MAX_ROWS; r++) begin
            row_vars_q[r] <= '0;
            piv_q[r]      <= '0;
         end
`ifdef GF2_SOLVE_SOL_VEC_EN
         best_sol_q <= '0;
         min_sol    <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rows_q   <= rows_eff;
                  ridx_q   <= '0;
                  free_q   <= vmask_in;
                  incons_q <= 1'b0;
                  s_q      <= '0;
                  best_q   <= '1;
                  busy     <= 1'b1;
                  for (int r = 0; r < MAX_ROWS; r++) begin
                     row_vars_q[r] <= RREF[r][VW-1:0] & vmask_in;
                     rhs_q[r]      <= |(RREF[r] & rhs_sel_in);
                     piv_q[r]      <= '0;
                  end
                  state <= (rows_eff == '0) ? ENUM : SCAN;
               end
            end
            SCAN: begin
               if (piv_hit) begin
                  piv_q[ridx_q]   <= '{vld: 1'b1, col: piv_col};
                  free_q[piv_col] <= 1'b0;
               end
               incons_q <= scan_incons;
               ridx_q   <= ridx_q + RIDX_W'(1);
               if (row_last) begin
                  if (scan_incons) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     busy       <= 1'b0;
                     sol_ok     <= 1'b0;
                     min_weight <= '0;
`ifdef GF2_SOLVE_SOL_VEC_EN
                     min_sol    <= '0;
`endif
                  end else begin
                     state <= ENUM;
                  end
               end
            end
            ENUM: begin
`ifdef GF2_SOLVE_SOL_VEC_EN
               if (better) begin
                  best_q     <= w_c;
                  best_sol_q <= x_c;
               end
`else
               if (better) best_q <= w_c;
`endif
               s_q <= s_next;
               if (s_next == '0) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  sol_ok     <= 1'b1;
                  min_weight <= better ? w_c : best_q;
`ifdef GF2_SOLVE_SOL_VEC_EN
                  min_sol    <= better ? x_c : best_sol_q;
`endif
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2_min_weight_solve.sv
// Scoreboard bench for gf2_min_weight_solve: brute-force reference model, latency and result checks.
module tb_gf2_min_weight_solve;

   localparam int MR     = 4;
   localparam int MC     = 7;
   localparam int ROWS_W = $clog2(MR + 1);
   localparam int COLS_W = $clog2(MC + 1);
   localparam int VW     = MC - 1;

   typedef struct {
      int done_cyc;
      int ok;
      int w;
      int sol;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [ROWS_W-1:0]        rows = '0;
   logic [COLS_W-1:0]        cols = '0;
   logic                     start = 1'b0;
   logic [MR-1:0][MC-1:0]    mat = '0;
   logic                     busy;
   logic                     done;
   logic                     sol_ok;
   logic [COLS_W-1:0]        min_weight;
`ifdef GF2_SOLVE_SOL_VEC_EN
   logic [VW-1:0]            min_sol;
`endif

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q [$];
   logic prev_done = 1'b0;

   gf2_min_weight_solve dut (
      .clk        (clk),
      .rst        (rst),
      .rows       (rows),
      .cols       (cols),
      .start      (start),
      .RREF       (mat),
      .busy       (busy),
      .done       (done),
      .sol_ok     (sol_ok),
      .min_weight (min_weight)
`ifdef GF2_SOLVE_SOL_VEC_EN
      ,
      .min_sol    (min_sol)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input int got, input int expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   // Exhaustive search over all variable vectors; ties go to the smallest free-variable part.
   task automatic model(input int r, input int c, input logic [MR-1:0][MC-1:0] m,
                        output int ok, output int w, output int sol, output int lat);
      int rr, cc, nv, vmask, free, rv, best_w, best_key, best_x, par, rhs, okx;
      rr = (r > MR) ? MR : r;
      cc = (c > MC) ? MC : ((c < 1) ? 1 : c);
      nv = cc - 1;
      vmask = (1 << nv) - 1;
      free = vmask;
      for (int i = 0; i < rr; i++) begin
         rv = int'(m[i]) & vmask;
         if (rv != 0) free = free & ~(rv & -rv);
      end
      best_w = 99; best_key = 1 << 30; best_x = 0;
      for (int x = 0; x <= vmask; x++) begin
         okx = 1;
         for (int i = 0; i < rr; i++) begin
            par = $countones(int'(m[i]) & vmask & x) & 1;
            rhs = (int'(m[i]) >> (cc - 1)) & 1;
            if (par != rhs) okx = 0;
         end
         if (okx == 1) begin
            if ($countones(x) < best_w || ($countones(x) == best_w && (x & free) < best_key)) begin
               best_w   = $countones(x);
               best_key = x & free;
               best_x   = x;
            end
         end
      end
      ok  = (best_w != 99) ? 1 : 0;
      w   = ok ? best_w : 0;
      sol = ok ? best_x : 0;
      lat = ok ? rr + (1 << $countones(free)) + 1 : rr + 1;
   endtask

   // Drive a request at a post-edge point; hold keeps start high for extra edges.
   task automatic launch(input int r, input int c, input logic [MR-1:0][MC-1:0] m, input int hold);
      exp_t e;
      int ok, w, sol, lat;
      model(r, c, m, ok, w, sol, lat);
      e.done_cyc = cyc + 1 + hold + lat - 1;
      e.ok = ok; e.w = w; e.sol = sol;
      exp_q.push_back(e);
      rows  = ROWS_W'(r);
      cols  = COLS_W'(c);
      mat   = m;
      start = 1'b1;
      repeat (1 + hold) @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) check_val("done_timeout", 0, 1);
   endtask

   task automatic run_case(input int r, input int c, input logic [MR-1:0][MC-1:0] m);
      launch(r, c, m, 0);
      wait_done(100);
      @(posedge clk); #1;
   endtask

   // Monitor: every done pulse is matched against the oldest queued expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (done) begin
         check_val("done_pulse_width", int'(prev_done), 0);
         if (exp_q.size() == 0) begin
            check_val("spurious_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_val("done_cycle", cyc, e.done_cyc);
            check_val("busy_at_done", int'(busy), 0);
            check_val("sol_ok", int'(sol_ok), e.ok);
            check_val("min_weight", int'(min_weight), e.w);
`ifdef GF2_SOLVE_SOL_VEC_EN
            check_val("min_sol", int'(min_sol), e.sol);
`endif
         end
      end
      prev_done = done;
   end

   logic [MR-1:0][MC-1:0] m_t1, m_t2, m_t3, m_t4, m_c1a, m_c1b, m_big, m_tie;

   initial begin
      m_t1  = {7'b0, 7'b0, 7'b0000110, 7'b0001101};
      m_t2  = {7'b0, 7'b0, 7'b0001000, 7'b0001101};
      m_t3  = '0;
      m_t4  = {7'b0, 7'b0001100, 7'b0001010, 7'b0001001};
      m_c1a = {7'b0, 7'b0, 7'b0000001, 7'b0000000};
      m_c1b = '0;
      m_big = {7'b0001000, 7'b1110100, 7'b0100010, 7'b1010001};
      m_tie = {7'b0, 7'b0, 7'b0011010, 7'b0101101};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_done", int'(done), 0);
      check_val("rst_sol_ok", int'(sol_ok), 0);
      check_val("rst_min_weight", int'(min_weight), 0);
`ifdef GF2_SOLVE_SOL_VEC_EN
      check_val("rst_min_sol", int'(min_sol), 0);
`endif
      @(posedge clk); #1;

      run_case(2, 4, m_t1);
      run_case(2, 4, m_t2);
      run_case(0, 4, m_t3);
      run_case(3, 4, m_t4);
      run_case(2, 1, m_c1a);
      run_case(2, 1, m_c1b);
      run_case(7, 7, m_big);
      run_case(2, 6, m_tie);

      // Start pulses during ENUM are ignored; next request is held across the DONE cycle.
      launch(0, 4, m_t3, 0);
      repeat (3) @(posedge clk);
      #1;
      check_val("busy_mid_enum", int'(busy), 1);
      rows = 2; cols = 4; mat = m_t1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(100);
      launch(3, 4, m_t4, 1);
      wait_done(100);
      @(posedge clk); #1;

      // Reset during ENUM aborts the run with no done pulse afterwards.
      launch(0, 4, m_t3, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check_val("abort_busy", int'(busy), 0);
      check_val("abort_done", int'(done), 0);
      check_val("abort_sol_ok", int'(sol_ok), 0);
      check_val("abort_min_weight", int'(min_weight), 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (15) @(posedge clk);
      #1;
      check_val("abort_idle_busy", int'(busy), 0);

      check_val("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
